// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-measurement sequencer.
// Holds the FSM state encoding, Status codes and frame layout.
package freq_meas_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_WAIT_DONE,
        S_LATCH,
        S_SEND_REQ,
        S_SEND_ACK,
        S_SEND_WAIT
    } state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MEAS = 2'b01,
        ST_SEND = 2'b10,
        ST_ERR  = 2'b11
    } status_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/freq_frame_mux.sv
// Frame byte selector: maps the byte index onto header, counts, checksum.
// Checksum is the XOR of the count bytes with bit0 carrying the error flag.
module freq_frame_mux
    import freq_meas_pkg::*;
(
    input  logic [31:0] sig_cnt,
    input  logic [31:0] base_cnt,
    input  logic        err_flag,
    input  logic [3:0]  idx,
    output logic [7:0]  frame_byte
);

    logic [7:0] csum;

    // XOR of bytes 1..8, error flag folded into bit0
    always_comb begin
        csum = sig_cnt[31:24] ^ sig_cnt[23:16]
             ^ sig_cnt[15:8]  ^ sig_cnt[7:0]
             ^ base_cnt[31:24] ^ base_cnt[23:16]
             ^ base_cnt[15:8]  ^ base_cnt[7:0];
        csum[0] = csum[0] ^ err_flag;
    end

    // Byte select, MSB first
    always_comb begin
        unique case (idx)
            4'd1:    frame_byte = sig_cnt[31:24];
            4'd2:    frame_byte = sig_cnt[23:16];
            4'd3:    frame_byte = sig_cnt[15:8];
            4'd4:    frame_byte = sig_cnt[7:0];
            4'd5:    frame_byte = base_cnt[31:24];
            4'd6:    frame_byte = base_cnt[23:16];
            4'd7:    frame_byte = base_cnt[15:8];
            4'd8:    frame_byte = base_cnt[7:0];
            4'd9:    frame_byte = csum;
            default: frame_byte = FRAME_HDR;
        endcase
    end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: clear, gate window, wait for datapath, then
// stream a 10-byte result frame to the SPI sender.
module freq_meas_ctrl #(
    parameter int GATE_CYCLES  = 100_000_000,
    parameter int DONE_TIMEOUT = 1_000_000,
    parameter int ACK_TIMEOUT  = 4096,
    parameter bit AUTO_RESTART = 1'b1
) (
    input  logic        baseClk,
    input  logic        hard_Clr_n,
    input  logic        start,
    output logic        gate,
    output logic        cnt_clr,
    input  logic        cnt_done,
    input  logic [31:0] sigCnt,
    input  logic [31:0] baseCnt,
    output logic [7:0]  data,
    output logic        sendEnable,
    input  logic        sendBusy,
    output logic [1:0]  Status
);
    import freq_meas_pkg::*;

    localparam int TMR_MAX = max3(GATE_CYCLES, DONE_TIMEOUT, ACK_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] GATE_LD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DONE_LD = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] ACK_LD  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       LAST_IX = 4'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             tmr_zero;
    logic [3:0]       idx;
    logic [31:0]      sig_q;
    logic [31:0]      base_q;
    logic             err_q;
    logic             ack_err;
    logic             restart_q;
    logic [7:0]       data_q;
    logic [7:0]       frame_byte;

    assign tmr_zero = (tmr == '0);

    freq_frame_mux u_mux (
        .sig_cnt    (sig_q),
        .base_cnt   (base_q),
        .err_flag   (err_q),
        .idx        (idx),
        .frame_byte (frame_byte)
    );

    // State register
    always_ff @(posedge baseClk or negedge hard_Clr_n) begin
        if (!hard_Clr_n) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (start || restart_q) state_nxt = S_CLEAR;
            S_CLEAR:     state_nxt = S_GATE;
            S_GATE:      if (tmr_zero) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (cnt_done || tmr_zero) state_nxt = S_LATCH;
            S_LATCH:     state_nxt = S_SEND_REQ;
            S_SEND_REQ:  state_nxt = S_SEND_ACK;
            S_SEND_ACK: begin
                if (sendBusy)      state_nxt = S_SEND_WAIT;
                else if (tmr_zero) state_nxt = S_IDLE;
            end
            S_SEND_WAIT: begin
                if (!sendBusy)
                    state_nxt = (idx == LAST_IX) ? S_IDLE : S_SEND_REQ;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Shared down-counter: gate length, done timeout, ack timeout
    always_ff @(posedge baseClk or negedge hard_Clr_n) begin
        if (!hard_Clr_n)                      tmr <= '0;
        else if (state == S_CLEAR)            tmr <= GATE_LD;
        else if (state == S_GATE && tmr_zero) tmr <= DONE_LD;
        else if (state == S_SEND_REQ)         tmr <= ACK_LD;
        else if (!tmr_zero)                   tmr <= tmr - 1'b1;
    end

    // Latched counts, byte index, error and restart flags
    always_ff @(posedge baseClk or negedge hard_Clr_n) begin
        if (!hard_Clr_n) begin
            sig_q     <= '0;
            base_q    <= '0;
            err_q     <= 1'b0;
            idx       <= '0;
            data_q    <= '0;
            ack_err   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            if (state == S_WAIT_DONE && state_nxt == S_LATCH)
                err_q <= !cnt_done;
            if (state == S_LATCH) begin
                sig_q  <= err_q ? '0 : sigCnt;
                base_q <= err_q ? '0 : baseCnt;
                idx    <= '0;
            end
            if (state == S_SEND_WAIT && state_nxt == S_SEND_REQ)
                idx <= idx + 1'b1;
            if (state == S_SEND_REQ)
                data_q <= frame_byte;
            if (state == S_SEND_ACK && state_nxt == S_IDLE)
                ack_err <= 1'b1;
            else if (state == S_IDLE && start)
                ack_err <= 1'b0;
            if (state == S_SEND_WAIT && state_nxt == S_IDLE)
                restart_q <= AUTO_RESTART;
            else if (state == S_IDLE)
                restart_q <= 1'b0;
        end
    end

    // Outputs decoded from state; data holds between requests
    always_comb begin
        gate       = (state == S_GATE);
        cnt_clr    = (state == S_CLEAR);
        sendEnable = (state == S_SEND_REQ);
        data       = sendEnable ? frame_byte : data_q;
        unique case (state)
            S_IDLE:
                Status = ack_err ? ST_ERR : ST_IDLE;
            S_CLEAR, S_GATE, S_WAIT_DONE:
                Status = ST_MEAS;
            default:
                Status = err_q ? ST_ERR : ST_SEND;
        endcase
    end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl with datapath and SPI models.
// Frames are compared against a byte-level reference of the frame format.
module tb_freq_meas_ctrl;

    localparam int GATE_N = 1000;
    localparam int DONE_N = 50;
    localparam int ACK_N  = 16;
    localparam int BUSY_N = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cnt_done = 1'b0;
    logic        send_busy = 1'b0;
    logic [31:0] sig_cnt = '0;
    logic [31:0] base_cnt = '0;
    logic        gate;
    logic        cnt_clr;
    logic        send_en;
    logic [7:0]  data;
    logic [1:0]  status;

    int n_vec = 0;
    int n_err = 0;

    int         neg = 0;
    logic [7:0] rx_q[$];
    int         last_en_neg = 0;
    int         en_total = 0;
    int         clr_total = 0;
    int         clr_neg = 0;
    int         drop_neg = 0;
    int         gate_run = 0;
    int         gate_len = 0;
    int         busy_left = 0;
    int         done_left = 0;
    bit         tie_lo = 1'b0;
    bit         done_en = 1'b1;
    logic       gate_d = 1'b0;
    logic [1:0] exp_st = 2'b10;

    always #5 clk = ~clk;

    freq_meas_ctrl #(
        .GATE_CYCLES  (GATE_N),
        .DONE_TIMEOUT (DONE_N),
        .ACK_TIMEOUT  (ACK_N),
        .AUTO_RESTART (1'b1)
    ) dut (
        .baseClk    (clk),
        .hard_Clr_n (rst_n),
        .start      (start),
        .gate       (gate),
        .cnt_clr    (cnt_clr),
        .cnt_done   (cnt_done),
        .sigCnt     (sig_cnt),
        .baseCnt    (base_cnt),
        .data       (data),
        .sendEnable (send_en),
        .sendBusy   (send_busy),
        .Status     (status)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int i, input logic [31:0] s,
                                            input logic [31:0] b, input bit err);
        logic [7:0]  fb[10];
        logic [7:0]  x;
        logic [31:0] ss;
        logic [31:0] bb;
        ss = err ? 32'd0 : s;
        bb = err ? 32'd0 : b;
        fb[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            fb[1+k] = 8'(ss >> (24 - 8*k));
            fb[5+k] = 8'(bb >> (24 - 8*k));
        end
        x = 8'h00;
        for (int k = 1; k < 9; k++) x = x ^ fb[k];
        fb[9] = {x[7:1], x[0] ^ err};
        return fb[i];
    endfunction

    // Monitor plus datapath and SPI sender models, all on the falling edge
    initial forever begin
        @(negedge clk);
        neg++;
        if (send_en) begin
            if (rx_q.size() > 0)
                chk("en_gap", 64'((neg - last_en_neg) >= BUSY_N), 1);
            chk("st_send", status, exp_st);
            rx_q.push_back(data);
            last_en_neg = neg;
            en_total++;
        end
        if (cnt_clr) begin
            clr_total++;
            clr_neg = neg;
        end
        if (gate) gate_run++;
        else if (gate_d) begin
            gate_len = gate_run;
            gate_run = 0;
        end
        if (gate_d && !gate) begin
            cnt_done  = 1'b0;
            done_left = done_en ? 20 : 0;
        end else if (done_left > 0) begin
            done_left--;
            if (done_left == 0) cnt_done = 1'b1;
        end
        gate_d = gate;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                send_busy = 1'b0;
                drop_neg  = neg;
            end
        end else if (send_en && !tie_lo) begin
            send_busy = 1'b1;
            busy_left = BUSY_N;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int b = 0;
        while (rx_q.size() < n && b < 6000) begin
            tick();
            b++;
        end
        chk({tag, "_tmo"}, 64'(rx_q.size() >= n), 1);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] s,
                               input logic [31:0] b, input bit err);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size())
                chk($sformatf("%s_b%0d", tag, i), rx_q[i], ref_byte(i, s, b, err));
        end
    endtask

    initial begin
        int c0;
        int c1;
        int e0;
        int bw;
        repeat (3) tick();
        chk("rst_gate", gate, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_en", send_en, 0);
        chk("rst_data", data, 0);
        chk("rst_st", status, 0);
        rst_n = 1'b1;
        tick();

        // Fixed-count frame, start ignored while sending
        sig_cnt  = 32'h0000_0064;
        base_cnt = 32'h0000_03E8;
        exp_st   = 2'b10;
        c0 = clr_total;
        pulse_start();
        chk("st_meas", status, 2'b01);
        wait_bytes(5, "f1a");
        repeat (10) tick();
        pulse_start();
        wait_bytes(10, "f1");
        check_frame("f1", 32'h64, 32'h3E8, 1'b0);
        chk("f1_gate_len", gate_len, GATE_N);
        chk("f1_clr_cnt", clr_total - c0, 1);

        // Auto restart, random counts, start ignored during gate
        sig_cnt  = $urandom();
        base_cnt = $urandom();
        rx_q.delete();
        c1 = clr_total;
        bw = 0;
        while (clr_total == c1 && bw < 500) begin
            tick();
            bw++;
        end
        chk("restart_seen", clr_total - c1, 1);
        chk("restart_gap", clr_neg - drop_neg, 2);
        repeat (100) tick();
        pulse_start();
        wait_bytes(10, "f2");
        check_frame("f2", sig_cnt, base_cnt, 1'b0);
        chk("f2_gate_len", gate_len, GATE_N);
        chk("f2_clr_cnt", clr_total - c0, 2);

        // Done timeout: zeroed counts, error flag in checksum
        done_en  = 1'b0;
        sig_cnt  = $urandom();
        base_cnt = $urandom();
        exp_st   = 2'b11;
        rx_q.delete();
        wait_bytes(10, "f3");
        check_frame("f3", sig_cnt, base_cnt, 1'b1);

        // Ack timeout: one request, sticky error, no restart
        done_en = 1'b1;
        tie_lo  = 1'b1;
        exp_st  = 2'b10;
        rx_q.delete();
        wait_bytes(1, "f4");
        bw = 0;
        while (neg < last_en_neg + ACK_N && bw < 100) begin
            tick();
            bw++;
        end
        chk("ack_st_pre", status, 2'b10);
        tick();
        chk("ack_st_err", status, 2'b11);
        e0 = en_total;
        c1 = clr_total;
        repeat (60) tick();
        chk("ack_no_en", en_total - e0, 0);
        chk("ack_no_restart", clr_total - c1, 0);
        chk("ack_sticky", status, 2'b11);
        tie_lo = 1'b0;
        pulse_start();
        chk("st_restart", status, 2'b01);

        // Asynchronous reset in the middle of a frame
        sig_cnt  = $urandom();
        base_cnt = $urandom();
        rx_q.delete();
        wait_bytes(5, "f5");
        repeat ($urandom_range(5, 60)) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gate", gate, 0);
        chk("arst_clr", cnt_clr, 0);
        chk("arst_en", send_en, 0);
        chk("arst_data", data, 0);
        chk("arst_st", status, 0);
        busy_left = 0;
        send_busy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        e0 = en_total;
        c1 = clr_total;
        repeat (200) tick();
        chk("post_rst_en", en_total - e0, 0);
        chk("post_rst_clr", clr_total - c1, 0);
        rx_q.delete();
        sig_cnt  = $urandom();
        base_cnt = $urandom();
        pulse_start();
        wait_bytes(10, "f6");
        check_frame("f6", sig_cnt, base_cnt, 1'b0);
        chk("f6_gate_len", gate_len, GATE_N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
